// File: rtl/mem_access_arbiter_if.sv
// Bus bundle between the arbiter, its two clients (IFU, LSU) and the unified memory port.
// The master modport is the arbiter's view; slave is the view of the clients and memory.
interface mem_access_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned INST_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 8
);
    // IFU side
    logic                  iIfuReqValid;
    logic                  oIfuReqReady;
    logic [ADDR_WIDTH-1:0] iIfuAddr;
    logic                  oIfuRespValid;
    logic [INST_WIDTH-1:0] oIfuRdData;
    // LSU side
    logic                  iLsuReqValid;
    logic                  oLsuReqReady;
    logic                  iLsuWrEn;
    logic [ADDR_WIDTH-1:0] iLsuAddr;
    logic [DATA_WIDTH-1:0] iLsuWrData;
    logic [LEN_WIDTH-1:0]  iLsuWrLen;
    logic                  oLsuRespValid;
    logic [DATA_WIDTH-1:0] oLsuRdData;
    // Memory side
    logic                  oMemReqValid;
    logic                  iMemReqReady;
    logic                  oMemWrEn;
    logic [ADDR_WIDTH-1:0] oMemAddr;
    logic [DATA_WIDTH-1:0] oMemWrData;
    logic [LEN_WIDTH-1:0]  oMemLen;
    logic                  iMemRespValid;
    logic [DATA_WIDTH-1:0] iMemRdData;
    // Status
    logic                  oBusy;
    logic                  oTimeoutErr;

    modport master (
        input  iIfuReqValid, iIfuAddr,
        output oIfuReqReady, oIfuRespValid, oIfuRdData,
        input  iLsuReqValid, iLsuWrEn, iLsuAddr, iLsuWrData, iLsuWrLen,
        output oLsuReqReady, oLsuRespValid, oLsuRdData,
        output oMemReqValid, oMemWrEn, oMemAddr, oMemWrData, oMemLen,
        input  iMemReqReady, iMemRespValid, iMemRdData,
        output oBusy, oTimeoutErr
    );

    modport slave (
        output iIfuReqValid, iIfuAddr,
        input  oIfuReqReady, oIfuRespValid, oIfuRdData,
        output iLsuReqValid, iLsuWrEn, iLsuAddr, iLsuWrData, iLsuWrLen,
        input  oLsuReqReady, oLsuRespValid, oLsuRdData,
        input  oMemReqValid, oMemWrEn, oMemAddr, oMemWrData, oMemLen,
        output iMemReqReady, iMemRespValid, iMemRdData,
        input  oBusy, oTimeoutErr
    );
endinterface

// File: rtl/mem_access_arbiter.sv
// Shares one memory port between instruction fetch and load/store. One request in flight,
// round-robin on ties, response routed back to the owner, watchdog on a missing response.
module mem_access_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned INST_WIDTH     = 32,
    parameter int unsigned LEN_WIDTH      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic                  iClock,
    input logic                  iReset,
    mem_access_arbiter_if.master bus
);
    typedef enum logic [1:0] {StIdle, StIssue, StWaitResp, StResp} state_e;

    localparam logic OwnerIfu = 1'b0;
    localparam logic OwnerLsu = 1'b1;
    localparam int unsigned CntWidth = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CntWidth-1:0] TimeoutLimit = CntWidth'(TIMEOUT_CYCLES);

    state_e                state_q;
    logic                  owner_q;
    logic                  last_grant_q;
    logic                  mem_req_valid_q;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [CntWidth-1:0]   cnt_q;
    logic                  timeout_err_q;
    logic                  ifu_resp_valid_q;
    logic                  lsu_resp_valid_q;
    logic [INST_WIDTH-1:0] ifu_rd_data_q;
    logic [DATA_WIDTH-1:0] lsu_rd_data_q;

    logic                  idle;
    logic                  ifu_win;
    logic                  lsu_win;
    logic                  resp_fire;
    logic                  timeout_hit;
    logic [DATA_WIDTH-1:0] resp_data;
    logic [CntWidth-1:0]   cnt_next;

    // Winner selection: a lone requester wins, on a tie the one not granted last time wins.
    always_comb begin
        idle    = (state_q == StIdle);
        ifu_win = bus.iIfuReqValid && (!bus.iLsuReqValid || last_grant_q == OwnerLsu);
        lsu_win = bus.iLsuReqValid && !ifu_win;
    end

    // Response completion: memory data, or zero data when the watchdog expires.
    always_comb begin
        resp_fire   = 1'b0;
        timeout_hit = 1'b0;
        resp_data   = bus.iMemRdData;
        cnt_next    = cnt_q + CntWidth'(1);
        if (state_q == StIssue && bus.iMemReqReady && bus.iMemRespValid) begin
            resp_fire = 1'b1;
        end
        if (state_q == StWaitResp) begin
            if (bus.iMemRespValid) begin
                resp_fire = 1'b1;
            end else if (TIMEOUT_CYCLES != 0 && cnt_next == TimeoutLimit) begin
                resp_fire   = 1'b1;
                timeout_hit = 1'b1;
                resp_data   = '0;
            end
        end
    end

    // Transaction FSM with registered memory-side and response outputs.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_q          <= StIdle;
            owner_q          <= OwnerIfu;
            last_grant_q     <= OwnerLsu;
            mem_req_valid_q  <= 1'b0;
            wr_en_q          <= 1'b0;
            addr_q           <= '0;
            wr_data_q        <= '0;
            len_q            <= '0;
            cnt_q            <= '0;
            timeout_err_q    <= 1'b0;
            ifu_resp_valid_q <= 1'b0;
            lsu_resp_valid_q <= 1'b0;
            ifu_rd_data_q    <= '0;
            lsu_rd_data_q    <= '0;
        end else begin
            ifu_resp_valid_q <= 1'b0;
            lsu_resp_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (ifu_win || lsu_win) begin
                        owner_q         <= lsu_win;
                        last_grant_q    <= lsu_win;
                        mem_req_valid_q <= 1'b1;
                        state_q         <= StIssue;
                        if (lsu_win) begin
                            addr_q    <= bus.iLsuAddr;
                            wr_en_q   <= bus.iLsuWrEn;
                            wr_data_q <= bus.iLsuWrData;
                            len_q     <= bus.iLsuWrEn ? bus.iLsuWrLen : LEN_WIDTH'(8);
                        end else begin
                            addr_q    <= bus.iIfuAddr;
                            wr_en_q   <= 1'b0;
                            wr_data_q <= '0;
                            len_q     <= LEN_WIDTH'(4);
                        end
                    end
                end
                StIssue: begin
                    if (bus.iMemReqReady) begin
                        mem_req_valid_q <= 1'b0;
                        cnt_q           <= '0;
                        state_q         <= resp_fire ? StResp : StWaitResp;
                    end
                end
                StWaitResp: begin
                    if (resp_fire) begin
                        state_q <= StResp;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        cnt_q <= cnt_next;
                    end
                end
                StResp: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
            if (timeout_hit) begin
                timeout_err_q <= 1'b1;
            end
            if (resp_fire) begin
                if (owner_q == OwnerLsu) begin
                    lsu_resp_valid_q <= 1'b1;
                    lsu_rd_data_q    <= resp_data;
                end else begin
                    ifu_resp_valid_q <= 1'b1;
                    ifu_rd_data_q    <= resp_data[INST_WIDTH-1:0];
                end
            end
        end
    end

    // Ready is gated by reset so every output reads zero while reset is held.
    assign bus.oIfuReqReady  = iReset && idle && ifu_win;
    assign bus.oLsuReqReady  = iReset && idle && lsu_win;
    assign bus.oIfuRespValid = ifu_resp_valid_q;
    assign bus.oIfuRdData    = ifu_rd_data_q;
    assign bus.oLsuRespValid = lsu_resp_valid_q;
    assign bus.oLsuRdData    = lsu_rd_data_q;
    assign bus.oMemReqValid  = mem_req_valid_q;
    assign bus.oMemWrEn      = wr_en_q;
    assign bus.oMemAddr      = addr_q;
    assign bus.oMemWrData    = wr_data_q;
    assign bus.oMemLen       = len_q;
    assign bus.oBusy         = (state_q != StIdle);
    assign bus.oTimeoutErr   = timeout_err_q;
endmodule

// File: tb/tb_mem_access_arbiter.sv
// Randomized bench for mem_access_arbiter against a transaction-level reference model.
module tb_mem_access_arbiter;
    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
    localparam int unsigned IW = 32;
    localparam int unsigned LW = 8;
    localparam int unsigned TO = 5;

    logic iClock = 1'b0;
    logic iReset = 1'b0;

    mem_access_arbiter_if #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INST_WIDTH(IW), .LEN_WIDTH(LW)
    ) bus ();

    mem_access_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INST_WIDTH(IW), .LEN_WIDTH(LW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .iClock(iClock),
        .iReset(iReset),
        .bus(bus)
    );

    always #5 iClock = ~iClock;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model state: who was granted last, sticky error, held read data.
    int          last_grant = 1;
    logic        exp_err = 1'b0;
    logic [31:0] exp_ifu_rd = '0;
    logic [63:0] exp_lsu_rd = '0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge iClock);
        #1;
    endtask

    task automatic sample();
        @(negedge iClock);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ifu_ready"}, bus.oIfuReqReady, 0);
        check_val({tag, "_lsu_ready"}, bus.oLsuReqReady, 0);
        check_val({tag, "_ifu_resp"}, bus.oIfuRespValid, 0);
        check_val({tag, "_ifu_rd"}, bus.oIfuRdData, 0);
        check_val({tag, "_lsu_resp"}, bus.oLsuRespValid, 0);
        check_val({tag, "_lsu_rd"}, bus.oLsuRdData, 0);
        check_val({tag, "_mem_valid"}, bus.oMemReqValid, 0);
        check_val({tag, "_mem_wr"}, bus.oMemWrEn, 0);
        check_val({tag, "_mem_addr"}, bus.oMemAddr, 0);
        check_val({tag, "_mem_wdata"}, bus.oMemWrData, 0);
        check_val({tag, "_mem_len"}, bus.oMemLen, 0);
        check_val({tag, "_busy"}, bus.oBusy, 0);
        check_val({tag, "_err"}, bus.oTimeoutErr, 0);
    endtask

    task automatic clear_inputs();
        bus.iIfuReqValid  = 1'b0;
        bus.iIfuAddr      = '0;
        bus.iLsuReqValid  = 1'b0;
        bus.iLsuWrEn      = 1'b0;
        bus.iLsuAddr      = '0;
        bus.iLsuWrData    = '0;
        bus.iLsuWrLen     = '0;
        bus.iMemReqReady  = 1'b0;
        bus.iMemRespValid = 1'b0;
        bus.iMemRdData    = '0;
    endtask

    // One complete transaction. rdy_dly: issue cycles with memory not ready.
    // rsp_dly: 0 = response with the ready; k = response in k-th wait cycle; > TO = never.
    task automatic run_txn(input bit want_ifu, input bit want_lsu, input bit lsu_wr,
                           input int rdy_dly, input int rsp_dly,
                           input logic [63:0] ifu_addr, input logic [63:0] lsu_addr,
                           input logic [63:0] lsu_wdata, input logic [7:0] lsu_len,
                           input logic [63:0] mem_data);
        int          winner;
        int          n_wait;
        bit          timed_out;
        logic [63:0] exp_addr;
        logic        exp_wr;
        logic [7:0]  exp_len;
        logic [63:0] got_data;

        step();
        bus.iIfuReqValid  = want_ifu;
        bus.iIfuAddr      = ifu_addr;
        bus.iLsuReqValid  = want_lsu;
        bus.iLsuWrEn      = lsu_wr;
        bus.iLsuAddr      = lsu_addr;
        bus.iLsuWrData    = lsu_wdata;
        bus.iLsuWrLen     = lsu_len;
        bus.iMemReqReady  = 1'b0;
        bus.iMemRespValid = 1'b0;

        if (want_ifu && want_lsu) winner = (last_grant == 0) ? 1 : 0;
        else                      winner = want_ifu ? 0 : 1;
        if (winner == 0) begin
            exp_addr = ifu_addr;
            exp_wr   = 1'b0;
            exp_len  = 8'd4;
        end else begin
            exp_addr = lsu_addr;
            exp_wr   = lsu_wr;
            exp_len  = lsu_wr ? lsu_len : 8'd8;
        end
        timed_out = (rsp_dly > int'(TO));

        sample();
        check_val("ifu_req_ready", bus.oIfuReqReady, winner == 0);
        check_val("lsu_req_ready", bus.oLsuReqReady, winner == 1);
        check_val("busy_at_accept", bus.oBusy, 0);
        last_grant = winner;

        // Issue phase: request must stay valid and stable until the memory takes it.
        for (int i = 0; i <= rdy_dly; i++) begin
            step();
            if (i == 0) begin
                // Winner drops its request and scrambles its fields; the loser keeps waiting.
                if (winner == 0) begin
                    bus.iIfuReqValid = 1'b0;
                    bus.iIfuAddr     = {$urandom, $urandom};
                end else begin
                    bus.iLsuReqValid = 1'b0;
                    bus.iLsuAddr     = {$urandom, $urandom};
                    bus.iLsuWrData   = {$urandom, $urandom};
                    bus.iLsuWrLen    = 8'($urandom);
                    bus.iLsuWrEn     = 1'($urandom);
                end
            end
            bus.iMemReqReady = (i == rdy_dly);
            if (i == rdy_dly) begin
                bus.iMemRespValid = (rsp_dly == 0);
                bus.iMemRdData    = (rsp_dly == 0) ? mem_data : {$urandom, $urandom};
            end else begin
                bus.iMemRespValid = 1'($urandom_range(0, 1));
                bus.iMemRdData    = {$urandom, $urandom};
            end
            sample();
            check_val("issue_mem_valid", bus.oMemReqValid, 1);
            check_val("issue_mem_addr", bus.oMemAddr, exp_addr);
            check_val("issue_mem_wr", bus.oMemWrEn, exp_wr);
            check_val("issue_mem_len", bus.oMemLen, exp_len);
            if (winner == 1 && lsu_wr) check_val("issue_mem_wdata", bus.oMemWrData, lsu_wdata);
            check_val("issue_busy", bus.oBusy, 1);
            check_val("issue_no_ready", bus.oIfuReqReady | bus.oLsuReqReady, 0);
            check_val("issue_no_resp", bus.oIfuRespValid | bus.oLsuRespValid, 0);
        end

        // Wait phase: memory took the request, response still outstanding.
        if (rsp_dly > 0) begin
            n_wait = timed_out ? int'(TO) : rsp_dly;
            for (int w = 1; w <= n_wait; w++) begin
                step();
                bus.iMemReqReady  = 1'b0;
                bus.iMemRespValid = (w == rsp_dly);
                bus.iMemRdData    = (w == rsp_dly) ? mem_data : {$urandom, $urandom};
                sample();
                check_val("wait_mem_valid", bus.oMemReqValid, 0);
                check_val("wait_busy", bus.oBusy, 1);
                check_val("wait_no_resp", bus.oIfuRespValid | bus.oLsuRespValid, 0);
                check_val("wait_no_ready", bus.oIfuReqReady | bus.oLsuReqReady, 0);
            end
        end

        got_data = timed_out ? 64'd0 : mem_data;
        if (timed_out) exp_err = 1'b1;
        if (winner == 0) exp_ifu_rd = got_data[31:0];
        else             exp_lsu_rd = got_data;

        // Response cycle, with a stray memory response that must be ignored.
        step();
        bus.iMemReqReady  = 1'b0;
        bus.iMemRespValid = 1'($urandom_range(0, 1));
        bus.iMemRdData    = {$urandom, $urandom};
        sample();
        check_val("resp_ifu_valid", bus.oIfuRespValid, winner == 0);
        check_val("resp_lsu_valid", bus.oLsuRespValid, winner == 1);
        check_val("resp_ifu_rd", bus.oIfuRdData, exp_ifu_rd);
        check_val("resp_lsu_rd", bus.oLsuRdData, exp_lsu_rd);
        check_val("resp_err", bus.oTimeoutErr, exp_err);
        check_val("resp_busy", bus.oBusy, 1);
        check_val("resp_no_ready", bus.oIfuReqReady | bus.oLsuReqReady, 0);

        // Back in idle with no requests; another stray response must not pulse anything.
        step();
        bus.iIfuReqValid  = 1'b0;
        bus.iLsuReqValid  = 1'b0;
        bus.iMemRespValid = 1'($urandom_range(0, 1));
        bus.iMemRdData    = {$urandom, $urandom};
        sample();
        check_val("idle_busy", bus.oBusy, 0);
        check_val("idle_no_resp", bus.oIfuRespValid | bus.oLsuRespValid, 0);
        check_val("idle_mem_valid", bus.oMemReqValid, 0);
        check_val("idle_ifu_rd_hold", bus.oIfuRdData, exp_ifu_rd);
        check_val("idle_lsu_rd_hold", bus.oLsuRdData, exp_lsu_rd);
        check_val("idle_err", bus.oTimeoutErr, exp_err);
    endtask

    initial begin
        int unsigned want;

        clear_inputs();
        #1;
        // Both requesters valid during reset: still no ready, everything zero.
        bus.iIfuReqValid = 1'b1;
        bus.iLsuReqValid = 1'b1;
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge iClock);
        #1;
        clear_inputs();
        iReset = 1'b1;

        // Ties after reset alternate, IFU first.
        for (int k = 0; k < 4; k++) begin
            run_txn(1, 1, 0, 0, 0, {$urandom, $urandom}, {$urandom, $urandom},
                    64'd0, 8'd0, {$urandom, $urandom});
        end

        // Single IFU fetch, zero-latency memory.
        run_txn(1, 0, 0, 0, 0, 64'h8000_0000, 64'd0, 64'd0, 8'd0, 64'h0000_0297_0000_0413);

        // LSU store, ready delayed 3 cycles, ack 2 cycles later.
        run_txn(0, 1, 1, 3, 2, 64'd0, 64'h8000_1000, 64'hDEAD_BEEF, 8'd4,
                {$urandom, $urandom});

        // LSU load that never gets a response: watchdog fires.
        run_txn(0, 1, 0, 0, TO + 1, 64'd0, {$urandom, $urandom}, 64'd0, 8'd0,
                {$urandom, $urandom});

        // Randomized traffic; error must stay sticky.
        for (int k = 0; k < 40; k++) begin
            want = $urandom_range(1, 3);
            run_txn(want[0], want[1], 1'($urandom), $urandom_range(0, 3),
                    $urandom_range(0, TO + 1),
                    {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                    8'($urandom_range(1, 8)), {$urandom, $urandom});
        end

        // Reset asserted while waiting for a response.
        step();
        bus.iLsuReqValid = 1'b1;
        bus.iLsuAddr     = {$urandom, $urandom};
        bus.iLsuWrEn     = 1'b0;
        sample();
        step();
        bus.iLsuReqValid = 1'b0;
        bus.iMemReqReady = 1'b1;
        sample();
        step();
        bus.iMemReqReady = 1'b0;
        sample();
        check_val("pre_reset_busy", bus.oBusy, 1);
        check_val("pre_reset_mem_valid", bus.oMemReqValid, 0);
        #2;
        iReset = 1'b0;
        #1;
        check_all_zero("async_reset");
        bus.iIfuReqValid  = 1'b1;
        bus.iLsuReqValid  = 1'b1;
        bus.iMemRespValid = 1'b1;
        repeat (2) @(posedge iClock);
        #1;
        check_all_zero("held_reset");
        clear_inputs();
        iReset     = 1'b1;
        last_grant = 1;
        exp_err    = 1'b0;
        exp_ifu_rd = '0;
        exp_lsu_rd = '0;

        // Tie after reset grants IFU first again.
        run_txn(1, 1, 0, 1, 1, {$urandom, $urandom}, {$urandom, $urandom}, 64'd0, 8'd0,
                {$urandom, $urandom});
        run_txn(1, 1, 1, 0, 0, {$urandom, $urandom}, {$urandom, $urandom},
                {$urandom, $urandom}, 8'd3, {$urandom, $urandom});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Shares the single unified memory port between instruction fetch (IFU) and load/store (LSU) in the multi-cycle core.
- Accepts one request at a time, issues it to memory with a valid/ready handshake, and routes the response back to the owner.
- Round-robin on ties.
- Watchdog flags a memory response that never arrives.

Parameters:
ADDR_WIDTH, 64, address width
DATA_WIDTH, 64, data width
INST_WIDTH, 32, instruction width
LEN_WIDTH, 8, byte-length field width
TIMEOUT_CYCLES, 255, WAIT_RESP cycles before timeout; 0 disables the watchdog

Ports:
iClock  in  1  clock, rising edge
iReset  in  1  asynchronous, active-low reset
iIfuReqValid  in  1  IFU fetch request
oIfuReqReady  out  1  IFU request accepted this cycle when high with valid
iIfuAddr  in  ADDR_WIDTH  fetch address
oIfuRespValid  out  1  one-cycle response pulse
oIfuRdData  out  INST_WIDTH  fetched instruction
iLsuReqValid  in  1  LSU request
oLsuReqReady  out  1  LSU request accepted
iLsuWrEn  in  1  1 = store, 0 = load
iLsuAddr  in  ADDR_WIDTH  access address
iLsuWrData  in  DATA_WIDTH  store data
iLsuWrLen  in  LEN_WIDTH  store byte count
oLsuRespValid  out  1  one-cycle response pulse (loads and stores)
oLsuRdData  out  DATA_WIDTH  load data
oMemReqValid  out  1  memory request valid
iMemReqReady  in  1  memory accepts request
oMemWrEn  out  1  write request
oMemAddr  out  ADDR_WIDTH  address
oMemWrData  out  DATA_WIDTH  write data
oMemLen  out  LEN_WIDTH  byte length
iMemRespValid  in  1  memory response/ack
iMemRdData  in  DATA_WIDTH  read data
oBusy  out  1  state != IDLE
oTimeoutErr  out  1  sticky watchdog error

Behaviour:
- Reset (iReset low, asynchronous):
  - state = IDLE.
  - All outputs 0.
  - Latched request fields 0.
  - Timeout counter 0.
  - lastGrant = LSU, so IFU wins the first tie.
  - Reset during any state aborts the transaction; no response pulse is produced.
- IDLE:
  - Winner selection:
    - If only one requester is valid, it wins.
    - If both are valid, the one not equal to lastGrant wins.
  - oXReqReady is combinational: (state == IDLE) && winner == X && iXReqValid. It is never high for both requesters.
  - On acceptance:
    - Latch owner, addr, wrEn, wrData, len. len = 4 for IFU; 8 for LSU load; iLsuWrLen for LSU store.
    - Set lastGrant = owner.
    - Go to ISSUE.
- ISSUE:
  - oMemReqValid = 1.
  - oMemWrEn, oMemAddr, oMemWrData, oMemLen driven from the latched registers and held stable until iMemReqReady.
  - Transitions:
    - iMemReqReady with no iMemRespValid: go to WAIT_RESP and clear the timeout counter.
    - iMemReqReady and iMemRespValid in the same cycle (zero-latency memory): capture the response and go to RESP.
  - iMemRespValid without iMemReqReady is ignored.
- WAIT_RESP:
  - oMemReqValid = 0.
  - On iMemRespValid: capture iMemRdData and go to RESP.
  - Otherwise, when TIMEOUT_CYCLES != 0, the counter increments each cycle. On reaching TIMEOUT_CYCLES:
    - set oTimeoutErr (remains set until reset);
    - capture data = 0;
    - go to RESP.
- RESP (one cycle):
  - Owner's oXRespValid = 1.
  - IFU: oIfuRdData = captured[INST_WIDTH-1:0].
  - LSU: oLsuRdData = captured, forwarded unchanged on stores as well; the LSU ignores it on stores.
  - Next state is IDLE.
  - Rd data outputs hold their last value until the next response.
- Latency:
  - Accept at cycle N; earliest oMemReqValid at N+1.
  - With iMemReqReady and iMemRespValid both high at N+1, oXRespValid is at N+2.
  - One request in flight at most; the next acceptance is earliest in the cycle after RESP.
- Stray iMemRespValid in IDLE or RESP is ignored.
- Requests held valid while not accepted stay pending; the arbiter does not latch them early.

Test Plan:
- Single IFU fetch: addr 0x80000000, memory ready and resp in the same cycle with data 0x00000297_00000413 → oMemLen = 4, oMemWrEn = 0, oIfuRespValid pulses 2 cycles after acceptance, oIfuRdData = 0x00000413.
- Simultaneous IFU and LSU load requests after reset → IFU granted first, LSU second. Repeat the tie → IFU/LSU alternate. oIfuReqReady and oLsuReqReady are never both high.
- LSU store: addr 0x80001000, data 0xDEADBEEF, len 4; iMemReqReady delayed 3 cycles → oMemReqValid held and fields stable for 3 cycles; response ack after 2 more cycles → oLsuRespValid pulses once.
- Timeout with TIMEOUT_CYCLES = 5, memory never responds → after 5 WAIT_RESP cycles oTimeoutErr = 1, oLsuRespValid pulses with oLsuRdData = 0, state returns to IDLE, and oTimeoutErr remains 1 through subsequent requests.
- Reset asserted in WAIT_RESP → all outputs 0 immediately (asynchronous), no response pulse. After release, a pending tie grants IFU first.
- Stray iMemRespValid in IDLE → no oIfuRespValid or oLsuRespValid pulse, state unchanged.
